// File: rtl/dm_load_master.sv
// dm_load_master: MEM-stage load port. Turns one load request into a single-beat
// AXI4 read, holds the pipeline in stall while the read is outstanding, and
// presents aligned, sign/zero-extended data on a registered memout.
module dm_load_master #(
    parameter int unsigned     ID_W  = 4,
    parameter logic [ID_W-1:0] AR_ID = ID_W'(1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic [31:0]     req_addr,
    input  logic [2:0]      req_funct3,
    output logic            stall,
    output logic [31:0]     memout,
    output logic            memout_valid,
    output logic            load_err,
    output logic [ID_W-1:0] ARID_M,
    output logic [31:0]     ARADDR_M,
    output logic [3:0]      ARLEN_M,
    output logic [2:0]      ARSIZE_M,
    output logic [1:0]      ARBURST_M,
    output logic            ARVALID_M,
    input  logic            ARREADY_M,
    input  logic [ID_W-1:0] RID_M,
    input  logic [31:0]     RDATA_M,
    input  logic [1:0]      RRESP_M,
    input  logic            RLAST_M,
    input  logic            RVALID_M,
    output logic            RREADY_M
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] memout_q, memout_d;
    logic        load_err_q, load_err_d;

    // Single-beat reads never need RLAST, and only the slave-error bit of RRESP matters.
    logic unused_s;
    assign unused_s = ^{RLAST_M, RRESP_M[0]};

    // Halfword loads need an even address; word loads (including the
    // undefined encodings that fall back to LW) need a word-aligned address.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic r;
        case (f3)
            3'b000, 3'b100: r = 1'b0;
            3'b001, 3'b101: r = a[0];
            default:        r = (a != 2'b00);
        endcase
        return r;
    endfunction

    // Pick the addressed byte/halfword out of the 32-bit beat and extend it.
    function automatic logic [31:0] extract_load(input logic [2:0] f3,
                                                 input logic [1:0] a,
                                                 input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            2'd3:    b = rd[31:24];
            default: b = rd[7:0];
        endcase
        h = a[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = rd;
        endcase
        return r;
    endfunction

    // Next-state logic; memout/load_err only take new values on entry to DONE.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        funct3_d   = funct3_q;
        memout_d   = memout_q;
        load_err_d = load_err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr;
                    funct3_d = req_funct3;
                    if (is_misaligned(req_funct3, req_addr[1:0])) begin
                        state_d    = S_DONE;
                        memout_d   = 32'd0;
                        load_err_d = 1'b1;
                    end else begin
                        state_d = S_ADDR;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADDR: begin
                if (ARREADY_M) begin
                    state_d = S_DATA;
                end else begin
                    state_d = S_ADDR;
                end
            end
            S_DATA: begin
                // Beats carrying a foreign ID are accepted (RREADY is high) and dropped.
                if (RVALID_M && (RID_M == AR_ID)) begin
                    state_d    = S_DONE;
                    memout_d   = extract_load(funct3_q, addr_q[1:0], RDATA_M);
                    load_err_d = RRESP_M[1];
                end else begin
                    state_d = S_DATA;
                end
            end
            S_DONE: begin
                // req_valid here still belongs to the retiring load.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            addr_q     <= 32'd0;
            funct3_q   <= 3'd0;
            memout_q   <= 32'd0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            funct3_q   <= funct3_d;
            memout_q   <= memout_d;
            load_err_q <= load_err_d;
        end
    end

    // AXI outputs come from registers or state decode only; no input-to-output paths.
    assign ARID_M       = AR_ID;
    assign ARADDR_M     = {addr_q[31:2], 2'b00};
    assign ARLEN_M      = 4'd0;
    assign ARSIZE_M     = 3'b010;
    assign ARBURST_M    = 2'b01;
    assign ARVALID_M    = (state_q == S_ADDR);
    assign RREADY_M     = (state_q == S_DATA);

    // The request cycle itself must already stall, hence req_valid in the term.
    assign stall        = ((state_q == S_IDLE) && req_valid) ||
                          (state_q == S_ADDR) || (state_q == S_DATA);
    assign memout       = memout_q;
    assign memout_valid = (state_q == S_DONE);
    assign load_err     = load_err_q;

endmodule
